cmd_fifo_rr_arbiter: RTL and testbench

// Shares one frontend command FIFO write port among NUM_REQ requesters (cores/masters).

---
 rtl/cmd_fifo_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_cmd_fifo_rr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_fifo_rr_arbiter.sv
// cmd_fifo_rr_arbiter: round-robin arbiter feeding one command FIFO write port.
// Multi-beat commands lock the grant so their beats stay contiguous.
module cmd_fifo_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_W       = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_data,
  input  logic                          i_fifo_full,
  input  logic                          i_fifo_almost_full,
  output logic [ID_W-1:0]               o_grant_id,
  output logic                          o_locked,
  output logic                          o_err_overflow
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                 r_state;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [ID_W-1:0]        r_owner;
  logic [ID_W-1:0]        r_grant_id;
  logic                   r_fifo_wr_en;
  logic [DATA_WIDTH-1:0]  r_fifo_data;
  logic                   r_err_overflow;

  logic                   w_stall;
  logic                   w_any;
  logic [ID_W-1:0]        w_rr_idx;
  logic [ID_W-1:0]        w_sel;
  logic [NUM_REQ-1:0]     w_ready;
  logic                   w_accept;
  logic                   w_sel_last;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic [ID_W-1:0]        w_next_ptr;

  assign w_stall = i_fifo_full | i_fifo_almost_full;

  // First valid requester at or after rr_ptr, wrapping; lowest offset wins.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    w_any    = 1'b0;
    w_rr_idx = r_rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, r_rr_ptr} + (ID_W + 1)'(i);
      if (sum >= (ID_W + 1)'(NUM_REQ))
        sum = sum - (ID_W + 1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (i_req_valid[idx]) begin
        w_any    = 1'b1;
        w_rr_idx = idx;
      end
    end
  end

  assign w_sel = (r_state == S_LOCKED) ? r_owner : w_rr_idx;

  // Ready goes only to the owner while locked, else to the RR winner.
  always_comb begin
    w_ready = '0;
    if (i_rst_n && !w_stall) begin
      if (r_state == S_LOCKED)
        w_ready[r_owner] = 1'b1;
      else if (w_any)
        w_ready[w_rr_idx] = 1'b1;
    end
  end

  // Mux the selected requester's beat.
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_sel == ID_W'(k)) begin
        w_sel_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_last = i_req_last[k];
      end
    end
  end

  assign w_accept   = |(i_req_valid & w_ready);
  assign w_next_ptr = (w_sel == ID_W'(NUM_REQ - 1)) ? '0
                                                    : w_sel + ID_W'(1);

  // Arbitration state, registered write port and sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_owner        <= '0;
      r_grant_id     <= '0;
      r_fifo_wr_en   <= 1'b0;
      r_fifo_data    <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      r_fifo_wr_en   <= w_accept;
      r_err_overflow <= r_err_overflow | (r_fifo_wr_en & i_fifo_full);
      if (w_accept) begin
        r_fifo_data <= w_sel_data;
        r_grant_id  <= w_sel;
        if (w_sel_last) begin
          r_state  <= S_IDLE;
          r_rr_ptr <= w_next_ptr;
        end else begin
          r_state <= S_LOCKED;
          r_owner <= w_sel;
        end
      end
    end
  end

  assign o_req_ready    = w_ready;
  assign o_fifo_wr_en   = r_fifo_wr_en;
  assign o_fifo_data    = r_fifo_data;
  assign o_grant_id     = r_grant_id;
  assign o_locked       = (r_state == S_LOCKED);
  assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_cmd_fifo_rr_arbiter.sv
// tb_cmd_fifo_rr_arbiter: scoreboard bench with per-requester beat sources
// and a 16-deep FIFO occupancy model (almost_full at one slot left).
module tb_cmd_fifo_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  rdy;
  logic          wr_en;
  logic [DW-1:0] fdata;
  logic          full, af;
  logic [1:0]    grant;
  logic          locked, err;

  always #5 clk = ~clk;

  cmd_fifo_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(rdy), .o_fifo_wr_en(wr_en), .o_fifo_data(fdata),
    .i_fifo_full(full), .i_fifo_almost_full(af),
    .o_grant_id(grant), .o_locked(locked), .o_err_overflow(err)
  );

  typedef struct packed {
    logic          v;
    logic          l;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         mem[N][64];
  int            rd_p[N];
  int            n_b[N];
  logic [DW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [N-1:0]  hs = '0;
  int            cnt = 0;
  int            max_cnt = 0;
  logic          rd_on = 1'b1;
  logic          force_af = 1'b0;

  assign full = (cnt >= 16);
  assign af   = (cnt >= 15) | force_af;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic add(input int k, input logic v, input logic l,
                     input logic [DW-1:0] d);
    mem[k][n_b[k]] = '{v: v, l: l, d: d};
    n_b[k]++;
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++)
      if (rd_p[k] < n_b[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      rd_p[k] = 0;
      n_b[k]  = 0;
    end
    exp_q.delete();
    force_af = 1'b0;
    rd_on    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int max);
    int t = 0;
    while ((exp_q.size() != 0 || pending()) && t < max) begin
      @(negedge clk);
      t++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // FIFO occupancy model: one write per wr_en, one read per cycle if enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 0;
    else
      cnt <= cnt + (wr_en ? 1 : 0) - ((rd_on && cnt > 0) ? 1 : 0);
  end

  // Sample handshakes before the edge, then advance the beat sources.
  always begin
    @(posedge clk);
    if (rst_n) begin
      if (full | af) chk("stall_ready", rdy, 0);
      hs = req_valid & rdy;
      chk("hs_onehot", ($countones(hs) <= 1), 1);
    end else begin
      hs = '0;
    end
    #1;
    for (int k = 0; k < N; k++) begin
      if (rd_p[k] < n_b[k] && (hs[k] || !mem[k][rd_p[k]].v))
        rd_p[k]++;
      if (rd_p[k] < n_b[k]) begin
        req_valid[k]           = mem[k][rd_p[k]].v;
        req_last[k]            = mem[k][rd_p[k]].l;
        req_data[k*DW +: DW]   = mem[k][rd_p[k]].d;
      end else begin
        req_valid[k]           = 1'b0;
        req_last[k]            = 1'b0;
        req_data[k*DW +: DW]   = '0;
      end
    end
  end

  // Output side: latency-1 write strobe, scoreboard order, grant id.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("wr_en_lat", wr_en, |hs);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexp_wr", fdata, 64'hdead);
        end else begin
          chk("fifo_data", fdata, exp_q.pop_front());
        end
        for (int k = 0; k < N; k++)
          if (hs[k]) chk("grant_id", grant, k);
      end
      if (cnt > max_cnt) max_cnt = cnt;
    end
  end

  initial begin
    int t;
    for (int k = 0; k < N; k++) begin
      rd_p[k] = 0;
      n_b[k]  = 0;
    end

    // reset values, then idle
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_data", fdata, 0);
    chk("rst_grant", grant, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", rdy, 0);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_wr_en", wr_en, 0);
      chk("idle_err", err, 0);
      chk("idle_locked", locked, 0);
    end

    // all four streaming single-beat commands
    do_reset();
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < N; k++) begin
        add(k, 1'b1, 1'b1, DW'(32'hA0 + k));
        exp_q.push_back(DW'(32'hA0 + k));
      end
    drain("rr_drain", 100);

    // burst with bubble on req1, rr_ptr primed to 1
    do_reset();
    add(0, 1'b1, 1'b1, 32'h10);
    exp_q.push_back(32'h10);
    drain("prime_drain", 20);
    add(1, 1'b1, 1'b0, 32'hB0);
    add(1, 1'b0, 1'b0, 32'h0);
    add(1, 1'b1, 1'b0, 32'hB1);
    add(1, 1'b1, 1'b1, 32'hB2);
    add(0, 1'b1, 1'b1, 32'h20);
    add(2, 1'b1, 1'b1, 32'h22);
    exp_q.push_back(32'hB0);
    exp_q.push_back(32'hB1);
    exp_q.push_back(32'hB2);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h20);
    drain("burst_drain", 50);

    // backpressure with no reads
    do_reset();
    rd_on   = 1'b0;
    max_cnt = 0;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < N; k++) begin
        add(k, 1'b1, 1'b1, DW'(32'h400 + j * 4 + k));
        exp_q.push_back(DW'(32'h400 + j * 4 + k));
      end
    repeat (40) @(negedge clk);
    chk("bp_cnt", cnt, 16);
    chk("bp_left", exp_q.size(), 16);
    chk("bp_err", err, 0);
    chk("bp_wr_idle", wr_en, 0);
    rd_on = 1'b1;
    drain("bp_drain", 300);
    chk("bp_max", (max_cnt <= 16), 1);
    chk("bp_err2", err, 0);

    // stall mid-burst on req3 beat 2
    do_reset();
    add(0, 1'b1, 1'b1, 32'h50);
    add(0, 1'b1, 1'b1, 32'h51);
    add(3, 1'b1, 1'b0, 32'h30);
    add(3, 1'b1, 1'b0, 32'h31);
    add(3, 1'b1, 1'b0, 32'h32);
    add(3, 1'b1, 1'b1, 32'h33);
    exp_q.push_back(32'h50);
    exp_q.push_back(32'h30);
    exp_q.push_back(32'h31);
    exp_q.push_back(32'h32);
    exp_q.push_back(32'h33);
    exp_q.push_back(32'h51);
    t = 0;
    while (rd_p[3] < 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("st_reach", rd_p[3], 2);
    force_af = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("st_locked", locked, 1);
      chk("st_gid", grant, 3);
    end
    force_af = 1'b0;
    drain("st_drain", 50);

    // reset in the middle of a burst
    do_reset();
    add(2, 1'b1, 1'b0, 32'h70);
    add(2, 1'b1, 1'b0, 32'h71);
    add(2, 1'b1, 1'b0, 32'h72);
    add(2, 1'b1, 1'b1, 32'h73);
    exp_q.push_back(32'h70);
    exp_q.push_back(32'h71);
    exp_q.push_back(32'h72);
    exp_q.push_back(32'h73);
    t = 0;
    while (!locked && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rs_locked", locked, 1);
    #1;
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      rd_p[k] = 0;
      n_b[k]  = 0;
    end
    exp_q.delete();
    @(negedge clk);
    chk("rs_unlock", locked, 0);
    chk("rs_wr_en", wr_en, 0);
    chk("rs_grant", grant, 0);
    rst_n = 1'b1;
    add(3, 1'b1, 1'b1, 32'h63);
    add(0, 1'b1, 1'b1, 32'h60);
    exp_q.push_back(32'h60);
    exp_q.push_back(32'h63);
    drain("rs_drain", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
